// File: rtl/exe_mem_stage_param_if.sv
// EXE->MEM pipeline boundary: EXE-side instruction fields, pipeline control,
// and the registered MEM-side fields. master = EXE stage / hazard unit, slave = the register.
interface exe_mem_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5
);
  logic              stall;
  logic              flush;
  logic              exe_valid;
  logic              exe_wreg;
  logic              exe_m2reg;
  logic              exe_wmem;
  logic [DATA_W-1:0] exe_alu;
  logic [DATA_W-1:0] exe_b;
  logic [RN_W-1:0]   exe_rn;
  logic              exe_z;
  logic              exe_n;
  logic              exe_wz;
  logic [2:0]        exe_br_op;
  logic [DATA_W-1:0] exe_btarget;

  logic              mem_valid;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic              mem_wmem;
  logic              mem_branch;
  logic [DATA_W-1:0] mem_alu;
  logic [DATA_W-1:0] mem_b;
  logic [DATA_W-1:0] mem_btarget;
  logic [RN_W-1:0]   mem_rn;
  logic              mem_z;
  logic              mem_n;

  modport master (
    output stall, flush, exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_alu, exe_b,
           exe_rn, exe_z, exe_n, exe_wz, exe_br_op, exe_btarget,
    input  mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_branch, mem_alu, mem_b,
           mem_btarget, mem_rn, mem_z, mem_n
  );

  modport slave (
    input  stall, flush, exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_alu, exe_b,
           exe_rn, exe_z, exe_n, exe_wz, exe_br_op, exe_btarget,
    output mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_branch, mem_alu, mem_b,
           mem_btarget, mem_rn, mem_z, mem_n
  );
endinterface

// File: rtl/exe_mem_stage_param.sv
// EXE/MEM pipeline register with branch resolution and the architectural Z/N flag register.
// Priority per edge: reset > flush > stall > load; every output comes straight from a flop.
module exe_mem_stage_param #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5
) (
  input logic                  clk,
  input logic                  clrn,
  exe_mem_stage_param_if.slave bus
);
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLTZ = 3'b011;
  localparam logic [2:0] BR_BGEZ = 3'b100;
  localparam logic [2:0] BR_JUMP = 3'b101;

  logic              valid_q, wreg_q, m2reg_q, wmem_q, branch_q;
  logic [DATA_W-1:0] alu_q, b_q, btarget_q;
  logic [RN_W-1:0]   rn_q;
  logic              z_q, n_q;
  logic              ez, en, br_cond;

  // A flag-writing instruction in EXE resolves its own branch against its new flags.
  assign ez = bus.exe_wz ? bus.exe_z : z_q;
  assign en = bus.exe_wz ? bus.exe_n : n_q;

  always_comb begin
    br_cond = 1'b0;
    case (bus.exe_br_op)
      BR_BEQ:  br_cond = ez;
      BR_BNE:  br_cond = ~ez;
      BR_BLTZ: br_cond = en;
      BR_BGEZ: br_cond = ~en;
      BR_JUMP: br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      valid_q   <= 1'b0;
      wreg_q    <= 1'b0;
      m2reg_q   <= 1'b0;
      wmem_q    <= 1'b0;
      branch_q  <= 1'b0;
      alu_q     <= '0;
      b_q       <= '0;
      btarget_q <= '0;
      rn_q      <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
    end else if (bus.flush) begin
      // Bubble: kill controls only; data and flags keep their values.
      valid_q  <= 1'b0;
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
      branch_q <= 1'b0;
    end else if (!bus.stall) begin
      valid_q   <= bus.exe_valid;
      wreg_q    <= bus.exe_valid & bus.exe_wreg;
      m2reg_q   <= bus.exe_valid & bus.exe_m2reg;
      wmem_q    <= bus.exe_valid & bus.exe_wmem;
      branch_q  <= bus.exe_valid & br_cond;
      alu_q     <= bus.exe_alu;
      b_q       <= bus.exe_b;
      btarget_q <= bus.exe_btarget;
      rn_q      <= bus.exe_rn;
      if (bus.exe_valid && bus.exe_wz) begin
        z_q <= bus.exe_z;
        n_q <= bus.exe_n;
      end
    end
  end

  assign bus.mem_valid   = valid_q;
  assign bus.mem_wreg    = wreg_q;
  assign bus.mem_m2reg   = m2reg_q;
  assign bus.mem_wmem    = wmem_q;
  assign bus.mem_branch  = branch_q;
  assign bus.mem_alu     = alu_q;
  assign bus.mem_b       = b_q;
  assign bus.mem_btarget = btarget_q;
  assign bus.mem_rn      = rn_q;
  assign bus.mem_z       = z_q;
  assign bus.mem_n       = n_q;
endmodule

// File: tb/tb_exe_mem_stage_param.sv
// Directed bench for exe_mem_stage_param: vector table of per-cycle inputs and
// expected registered outputs, plus hand sequences for synchronous-reset corners.
module tb_exe_mem_stage_param;
  // ctl  = {clrn, stall, flush, valid, wreg, m2reg, wmem, z, n, wz}
  // ectl = {mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_branch, mem_z, mem_n}
  typedef struct {
    logic [9:0]  ctl;
    logic [2:0]  op;
    logic [31:0] alu, b, bt;
    logic [4:0]  rn;
    logic [6:0]  ectl;
    logic [31:0] ealu, eb, ebt;
    logic [4:0]  ern;
  } vec_t;

  logic clk = 1'b0;
  logic clrn;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  exe_mem_stage_param_if #(.DATA_W(32), .RN_W(5)) bus ();
  exe_mem_stage_param #(.DATA_W(32), .RN_W(5)) dut (.clk(clk), .clrn(clrn), .bus(bus.slave));

  function automatic vec_t mk(input logic [9:0] ctl, input logic [2:0] op,
                              input logic [31:0] alu, b, bt, input logic [4:0] rn,
                              input logic [6:0] ectl, input logic [31:0] ealu, eb, ebt,
                              input logic [4:0] ern);
    vec_t v;
    v.ctl = ctl; v.op = op; v.alu = alu; v.b = b; v.bt = bt; v.rn = rn;
    v.ectl = ectl; v.ealu = ealu; v.eb = eb; v.ebt = ebt; v.ern = ern;
    return v;
  endfunction

  function automatic logic [107:0] actual();
    return {bus.mem_valid, bus.mem_wreg, bus.mem_m2reg, bus.mem_wmem, bus.mem_branch,
            bus.mem_z, bus.mem_n, bus.mem_alu, bus.mem_b, bus.mem_btarget, bus.mem_rn};
  endfunction

  task automatic drive(input vec_t v);
    clrn            = v.ctl[9];
    bus.stall       = v.ctl[8];
    bus.flush       = v.ctl[7];
    bus.exe_valid   = v.ctl[6];
    bus.exe_wreg    = v.ctl[5];
    bus.exe_m2reg   = v.ctl[4];
    bus.exe_wmem    = v.ctl[3];
    bus.exe_z       = v.ctl[2];
    bus.exe_n       = v.ctl[1];
    bus.exe_wz      = v.ctl[0];
    bus.exe_br_op   = v.op;
    bus.exe_alu     = v.alu;
    bus.exe_b       = v.b;
    bus.exe_btarget = v.bt;
    bus.exe_rn      = v.rn;
  endtask

  task automatic check(input string name, input logic [107:0] exp);
    logic [107:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    // reset with everything else asserted
    vecs.push_back(mk(10'b0111111111, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31,
                      7'b0000000, 32'h0, 32'h0, 32'h0, 5'd0));
    // basic load
    vecs.push_back(mk(10'b1001100000, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 5'd7,
                      7'b1100000, 32'h1234, 32'h0, 32'h0, 5'd7));
    // set Z
    vecs.push_back(mk(10'b1001000101, 3'b000, 32'h5, 32'h0, 32'h0, 5'd0,
                      7'b1000010, 32'h5, 32'h0, 32'h0, 5'd0));
    // beq on held Z=1 (exe_z ignored since wz=0)
    vecs.push_back(mk(10'b1001000000, 3'b001, 32'h6, 32'h0, 32'h100, 5'd0,
                      7'b1000110, 32'h6, 32'h0, 32'h100, 5'd0));
    // bne on held Z=1
    vecs.push_back(mk(10'b1001000000, 3'b010, 32'h7, 32'h0, 32'h200, 5'd0,
                      7'b1000010, 32'h7, 32'h0, 32'h200, 5'd0));
    // set N=1, Z=0
    vecs.push_back(mk(10'b1001000011, 3'b000, 32'h8, 32'h0, 32'h0, 5'd0,
                      7'b1000001, 32'h8, 32'h0, 32'h0, 5'd0));
    // bltz with wz=1 n=0: bypass gives not-taken, N cleared
    vecs.push_back(mk(10'b1001000001, 3'b011, 32'h9, 32'h0, 32'h0, 5'd0,
                      7'b1000000, 32'h9, 32'h0, 32'h0, 5'd0));
    // bgez with wz=1 n=1: bypass gives not-taken, N set
    vecs.push_back(mk(10'b1001000011, 3'b100, 32'hA, 32'h0, 32'h0, 5'd0,
                      7'b1000001, 32'hA, 32'h0, 32'h0, 5'd0));
    // bltz on held N=1
    vecs.push_back(mk(10'b1001000000, 3'b011, 32'hB, 32'h0, 32'h0, 5'd0,
                      7'b1000101, 32'hB, 32'h0, 32'h0, 5'd0));
    // invalid jump: no controls, no flag write, data still loads
    vecs.push_back(mk(10'b1000100101, 3'b101, 32'hC, 32'h0, 32'h80, 5'd3,
                      7'b0000001, 32'hC, 32'h0, 32'h80, 5'd3));
    // valid jump
    vecs.push_back(mk(10'b1001000000, 3'b101, 32'h0, 32'h0, 32'h40, 5'd0,
                      7'b1000101, 32'h0, 32'h0, 32'h40, 5'd0));
    // store
    vecs.push_back(mk(10'b1001001000, 3'b000, 32'hA, 32'hB, 32'h0, 5'd2,
                      7'b1001001, 32'hA, 32'hB, 32'h0, 5'd2));
    // stall: hold everything including flags
    vecs.push_back(mk(10'b1101100101, 3'b101, 32'hFF, 32'hEE, 32'h99, 5'd9,
                      7'b1001001, 32'hA, 32'hB, 32'h0, 5'd2));
    // stall + flush: bubble, data and flags hold
    vecs.push_back(mk(10'b1111100101, 3'b101, 32'hFF, 32'hEE, 32'h99, 5'd9,
                      7'b0000001, 32'hA, 32'hB, 32'h0, 5'd2));
    // flush alone
    vecs.push_back(mk(10'b1011100111, 3'b101, 32'h77, 32'h66, 32'h55, 5'd8,
                      7'b0000001, 32'hA, 32'hB, 32'h0, 5'd2));
    // set both flags
    vecs.push_back(mk(10'b1001000111, 3'b000, 32'h20, 32'h0, 32'h0, 5'd0,
                      7'b1000011, 32'h20, 32'h0, 32'h0, 5'd0));
    // reset during stall clears flags too
    vecs.push_back(mk(10'b0101100111, 3'b101, 32'h55, 32'h44, 32'h33, 5'd5,
                      7'b0000000, 32'h0, 32'h0, 32'h0, 5'd0));
    // resume; op 110 behaves as none
    vecs.push_back(mk(10'b1001110000, 3'b110, 32'h33, 32'h0, 32'h10, 5'd4,
                      7'b1110000, 32'h33, 32'h0, 32'h10, 5'd4));
    // op 111 behaves as none, Z set
    vecs.push_back(mk(10'b1001000101, 3'b111, 32'h34, 32'h0, 32'h10, 5'd4,
                      7'b1000010, 32'h34, 32'h0, 32'h10, 5'd4));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      v = vecs[i];
      check($sformatf("vec%0d", i), {v.ectl, v.ealu, v.eb, v.ebt, v.ern});
    end

    // Reset is synchronous: dropping clrn mid-cycle changes nothing,
    // and raising it again before the edge lets the edge load normally.
    #2;
    clrn = 1'b0;
    #1;
    check("async_assert_no_effect", {7'b1000010, 32'h34, 32'h0, 32'h10, 5'd4});
    clrn = 1'b1;
    drive(mk(10'b1001000000, 3'b001, 32'h1111, 32'h2222, 32'h3333, 5'd6,
             7'b0, 32'h0, 32'h0, 32'h0, 5'd0));
    @(posedge clk);
    #1;
    check("clrn_pulse_between_edges", {7'b1000110, 32'h1111, 32'h2222, 32'h3333, 5'd6});

    // Reset during flush, then release mid-cycle: outputs stay zero until the edge.
    drive(mk(10'b0011100111, 3'b101, 32'h9, 32'h9, 32'h9, 5'd9,
             7'b0, 32'h0, 32'h0, 32'h0, 5'd0));
    @(posedge clk);
    #1;
    check("reset_mid_flush", {7'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    drive(mk(10'b1001000011, 3'b100, 32'h42, 32'h43, 32'h44, 5'd1,
             7'b0, 32'h0, 32'h0, 32'h0, 5'd0));
    #2;
    check("release_waits_for_edge", {7'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    @(posedge clk);
    #1;
    check("first_load_after_reset", {7'b1000001, 32'h42, 32'h43, 32'h44, 5'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exe_mem_stage_param.md
EXE_MEM_STAGE_PARAM -- requirements
Module: exe_mem_stage_param

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result, store data and branch target.
REQ-002 Parameter RN_W, default 5, width of destination register number.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset; reset is synchronous and active-low.
REQ-005 stall  input  1  hold all stage state this cycle.
REQ-006 flush  input  1  load a bubble into the stage this cycle.
REQ-007 exe_valid  input  1  EXE slot holds a real instruction.
REQ-008 exe_wreg, exe_m2reg, exe_wmem  input  1 each  EXE control bits.
REQ-009 exe_alu, exe_b  input  DATA_W each  ALU result, store data.
REQ-010 exe_rn  input  RN_W  destination register.
REQ-011 exe_z, exe_n  input  1 each  zero and negative flags from ALU.
REQ-012 exe_wz  input  1  instruction writes the flag register.
REQ-013 exe_br_op  input  3  000 none, 001 beq, 010 bne, 011 bltz, 100 bgez, 101 jump; 110/111 treated as none.
REQ-014 exe_btarget  input  DATA_W  branch/jump target.
REQ-015 mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_branch  output  1 each  registered controls.
REQ-016 mem_alu, mem_b, mem_btarget  output  DATA_W each; mem_rn  output  RN_W.
REQ-017 mem_z, mem_n  output  1 each  architectural flag register.

Function
REQ-018 Update priority per edge: reset > flush > stall > load.
REQ-019 Load: all mem_* data/control fields take EXE values one cycle later (latency 1).
REQ-020 Load with exe_valid=0: mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_branch load 0; data fields load EXE values.
REQ-021 Flush: mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_branch load 0; mem_alu, mem_b, mem_rn, mem_btarget hold.
REQ-022 Stall (flush=0): every register, including flags, holds.
REQ-023 Flag register (mem_z, mem_n) loads exe_z, exe_n only on a load cycle with exe_valid=1 and exe_wz=1; otherwise holds (never cleared except by reset).
REQ-024 Effective flags: ez = exe_wz ? exe_z : mem_z; en = exe_wz ? exe_n : mem_n (same-cycle bypass).
REQ-025 Branch condition: beq=ez, bne=~ez, bltz=en, bgez=~en, jump=1, none=0.
REQ-026 mem_branch loads (condition AND exe_valid) on a load cycle.
REQ-027 Flush and stall both asserted: flush wins, flags hold.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 clrn=0 at an edge: all outputs 0 (mem_valid, controls, mem_branch, mem_z, mem_n, mem_alu, mem_b, mem_rn, mem_btarget), regardless of stall/flush.
REQ-030 clrn asserted mid-stall or mid-flush: reset value after that edge; normal loading resumes on the first edge with clrn=1.
REQ-031 Reset is not asynchronous: deasserting clrn between edges changes nothing until the next edge.

Verification
REQ-032 Reset, then load valid, wreg=1, alu=0x0000_1234, rn=7 -> next cycle mem_valid=1, mem_wreg=1, mem_alu=0x1234, mem_rn=7.
REQ-033 Load wz=1, z=1; next instr beq, wz=0, valid=1 -> mem_branch=1 and mem_z stays 1; then bne, wz=0 -> mem_branch=0.
REQ-034 Load valid, wmem=1, alu=0xA; next cycle stall=1 with new inputs -> all outputs remain 0xA/wmem=1; stall+flush together -> mem_valid=0, mem_wmem=0, mem_alu=0xA.
REQ-035 Flags held at n=1; bltz with wz=1, n=0 -> mem_branch=0 (bypass used), mem_n=0 after edge.
REQ-036 jump with exe_valid=0 -> mem_branch=0; jump with exe_valid=1, btarget=0x40 -> mem_branch=1, mem_btarget=0x40.
REQ-037 Mid-stream clrn=0 with stall=1 and flags=1 -> all outputs 0 after that edge, including mem_z, mem_n.
